// File: rtl/move_undo_stack.sv
// LIFO recorder of scramble moves that replays their inverses, newest first, to the cube engine.
// Optional build macro: MOVE_CANCEL_EN (a push equal to the inverse of the top entry pops it instead).
module move_undo_stack #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push_valid,
  input  logic [3:0]        push_move,
  output logic              push_ready,
  input  logic              undo_start,
  output logic              move_valid,
  output logic [3:0]        move_out,
  input  logic              move_ready,
  output logic              busy,
  output logic              undo_done,
  output logic [ADDR_W:0]   depth,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, LOAD, PRESENT, DONE} state_t;

  localparam logic [ADDR_W:0] SP_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] SP_ONE  = (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W:0]   sp;
  logic [3:0]        mem [DEPTH];
  logic [ADDR_W-1:0] top_idx;
  logic [3:0]        top;
  logic              push_take;
  logic              cancel;
  logic              full;
  logic              write_en;

  assign push_ready = (state == IDLE) && !undo_start;
  assign busy       = (state != IDLE);
  assign depth      = sp;

  // When sp==DEPTH the low bits are zero, so the wrap below still lands on DEPTH-1.
  assign top_idx   = sp[ADDR_W-1:0] - 1'b1;
  assign top       = mem[top_idx];
  assign full      = (sp == SP_FULL);
  assign push_take = push_valid && push_ready && (push_move < 4'd12);

`ifdef MOVE_CANCEL_EN
  assign cancel = push_take && (sp != '0) && (push_move == (top ^ 4'b0001));
`else
  assign cancel = 1'b0;
`endif

  assign write_en = push_take && !cancel && !full;

  // NOTE: the move memory is deliberately left out of reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (write_en) mem[sp[ADDR_W-1:0]] <= push_move;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      sp         <= '0;
      move_valid <= 1'b0;
      move_out   <= 4'd0;
      undo_done  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      undo_done <= 1'b0;
      case (state)
        IDLE: begin
          if (undo_start) begin
            state <= (sp != '0) ? LOAD : DONE;
          end
          if (push_take) begin
            if (cancel)    sp       <= sp - 1'b1;
            else if (full) overflow <= 1'b1;
            else           sp       <= sp + 1'b1;
          end
        end
        LOAD: begin
          move_out   <= top ^ 4'b0001;
          move_valid <= 1'b1;
          state      <= PRESENT;
        end
        PRESENT: begin
          if (move_ready) begin
            sp         <= sp - 1'b1;
            move_valid <= 1'b0;
            state      <= (sp == SP_ONE) ? DONE : LOAD;
          end
        end
        DONE: begin
          undo_done <= 1'b1;
          overflow  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_undo_stack.sv
// Self-checking bench for move_undo_stack: directed scenarios plus randomized traffic against a queue model.
module tb_move_undo_stack;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic            clk = 1'b0;
  logic            resetn;
  logic            push_valid;
  logic [3:0]      push_move;
  logic            push_ready;
  logic            undo_start;
  logic            move_valid;
  logic [3:0]      move_out;
  logic            move_ready;
  logic            busy;
  logic            undo_done;
  logic [ADDR_W:0] depth;
  logic            overflow;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: recorded moves as a plain queue, newest at the back.
  int model[$];
  bit ovf_m = 1'b0;

  move_undo_stack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn),
    .push_valid(push_valid), .push_move(push_move), .push_ready(push_ready),
    .undo_start(undo_start),
    .move_valid(move_valid), .move_out(move_out), .move_ready(move_ready),
    .busy(busy), .undo_done(undo_done), .depth(depth), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_push(input int code);
    if (code >= 12) return;
`ifdef MOVE_CANCEL_EN
    if (model.size() > 0 && code == (model[model.size()-1] ^ 1)) begin
      void'(model.pop_back());
      return;
    end
`endif
    if (model.size() == DEPTH) ovf_m = 1'b1;
    else model.push_back(code);
  endfunction

  task automatic do_push(input int code);
    push_valid = 1'b1;
    push_move  = 4'(code);
    tick();
    push_valid = 1'b0;
    model_push(code);
    vectors++;
    if (int'(depth) !== model.size()) begin
      miscompares++;
      $display("FAIL push_depth code=%0d got=%0d exp=%0d", code, depth, model.size());
    end
    vectors++;
    if (overflow !== ovf_m) begin
      miscompares++;
      $display("FAIL push_overflow code=%0d got=%0b exp=%0b", code, overflow, ovf_m);
    end
  endtask

  // Runs a full replay; rand_ready stalls the engine randomly, noise throws pushes at the busy DUT.
  task automatic do_undo(input bit rand_ready, input bit noise);
    int exp_seq[$];
    int idx = 0;
    int cyc;
    int first_v = -1;
    int done_c  = -1;
    int budget  = 8 * DEPTH + 40;
    bit hs;
    for (int i = model.size() - 1; i >= 0; i--) exp_seq.push_back(model[i] ^ 1);
    undo_start = 1'b1;
    push_valid = noise;
    push_move  = 4'($urandom_range(0, 11));
    tick();
    undo_start = 1'b0;
    cyc = 1;
    while (cyc < budget) begin
      if (undo_done === 1'b1) begin
        done_c = cyc;
        break;
      end
      vectors++;
      if (push_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL push_ready_busy cyc=%0d got=%0b exp=0", cyc, push_ready);
      end
      if (move_valid === 1'b1) begin
        if (first_v < 0) first_v = cyc;
        vectors++;
        if (idx >= exp_seq.size()) begin
          miscompares++;
          $display("FAIL extra_move idx=%0d got=%0d exp=none", idx, move_out);
        end else if (move_out !== 4'(exp_seq[idx])) begin
          miscompares++;
          $display("FAIL move_out idx=%0d got=%0d exp=%0d", idx, move_out, exp_seq[idx]);
        end
      end
      move_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      push_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      push_move  = 4'($urandom_range(0, 15));
      hs = move_valid && move_ready;
      tick();
      cyc++;
      if (hs) idx++;
    end
    push_valid = 1'b0;
    move_ready = 1'b0;
    vectors++;
    if (done_c < 0) begin
      miscompares++;
      $display("FAIL undo_timeout got=no_done exp=undo_done within %0d cycles", budget);
    end
    vectors++;
    if (idx != exp_seq.size()) begin
      miscompares++;
      $display("FAIL replay_count got=%0d exp=%0d", idx, exp_seq.size());
    end
    vectors++;
    if (exp_seq.size() > 0 && first_v != 2) begin
      miscompares++;
      $display("FAIL first_valid_latency got=%0d exp=2", first_v);
    end else if (exp_seq.size() == 0 && (first_v != -1 || done_c != 2)) begin
      miscompares++;
      $display("FAIL empty_undo got valid_at=%0d done_at=%0d exp valid_at=-1 done_at=2", first_v, done_c);
    end
    vectors++;
    if (depth !== '0 || overflow !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_undo got depth=%0d ovf=%0b busy=%0b exp 0/0/0", depth, overflow, busy);
    end
    tick();
    vectors++;
    if (undo_done !== 1'b0) begin
      miscompares++;
      $display("FAIL undo_done_width got=%0b exp=0", undo_done);
    end
    model.delete();
    ovf_m = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    vectors++;
    if (depth !== '0 || move_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || undo_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset got depth=%0d mv=%0b busy=%0b ovf=%0b done=%0b exp all 0",
               depth, move_valid, busy, overflow, undo_done);
    end
    vectors++;
    if (push_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_push_ready got=%0b exp=1", push_ready);
    end
    resetn = 1'b1;
    tick();
    model.delete();
    ovf_m = 1'b0;
  endtask

  task automatic test_basic();
    do_push(3);
    do_push(8);
    do_push(0);
    do_undo(1'b0, 1'b1);
  endtask

  task automatic test_invalid_and_overflow();
    int prev = -1;
    int code;
    do_push(13);
    do_push(12);
    vectors++;
    if (depth !== '0) begin
      miscompares++;
      $display("FAIL invalid_codes got=%0d exp=0", depth);
    end
    for (int i = 0; i < DEPTH + 1; i++) begin
      do code = $urandom_range(0, 11); while (prev >= 0 && code == (prev ^ 1));
      do_push(code);
      prev = code;
    end
    vectors++;
    if (int'(depth) !== DEPTH || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow got depth=%0d ovf=%0b exp depth=%0d ovf=1", depth, overflow, DEPTH);
    end
    do_undo(1'b1, 1'b0);
  endtask

  task automatic test_empty_undo();
    do_undo(1'b0, 1'b0);
  endtask

  task automatic test_stall_and_reset();
    do_push(5);
    do_push(6);
    move_ready = 1'b0;
    undo_start = 1'b1;
    tick();
    undo_start = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (move_valid !== 1'b1 || move_out !== 4'd7 || int'(depth) !== 2) begin
        miscompares++;
        $display("FAIL stall_hold cyc=%0d got mv=%0b out=%0d depth=%0d exp 1/7/2", i, move_valid, move_out, depth);
      end
      tick();
    end
    resetn = 1'b0;
    tick();
    vectors++;
    if (move_valid !== 1'b0 || depth !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abort got mv=%0b depth=%0d busy=%0b exp 0/0/0", move_valid, depth, busy);
    end
    resetn = 1'b1;
    move_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (move_valid !== 1'b0 || undo_done !== 1'b0) begin
        miscompares++;
        $display("FAIL after_abort cyc=%0d got mv=%0b done=%0b exp 0/0", i, move_valid, undo_done);
      end
    end
    move_ready = 1'b0;
    model.delete();
    ovf_m = 1'b0;
  endtask

  task automatic test_cancel();
    do_push(4);
    do_push(5);
`ifdef MOVE_CANCEL_EN
    vectors++;
    if (depth !== '0) begin
      miscompares++;
      $display("FAIL cancel_pair got=%0d exp=0", depth);
    end
    do_push(4);
    do_push(4);
`endif
    vectors++;
    if (int'(depth) !== 2) begin
      miscompares++;
      $display("FAIL cancel_depth got=%0d exp=2", depth);
    end
    do_undo(1'b0, 1'b0);
  endtask

  task automatic test_random();
    int n;
    int code;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) begin
        if (model.size() > 0 && $urandom_range(0, 5) == 0) code = model[model.size()-1] ^ 1;
        else code = $urandom_range(0, 15);
        do_push(code);
      end
      do_undo(1'b1, 1'b1);
    end
  endtask

  initial begin
    resetn     = 1'b0;
    push_valid = 1'b0;
    push_move  = 4'd0;
    undo_start = 1'b0;
    move_ready = 1'b0;
    test_reset();
    test_basic();
    test_invalid_and_overflow();
    test_empty_undo();
    test_stall_and_reset();
    test_cancel();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
